// File: rtl/nonce_seq_pkg.sv
// Shared types and widths for the nonce sequencer and its round counter.
package nonce_seq_pkg;

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned NONCE_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    FOUND = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/round_counter.sv
// Modulo-ROUNDS round counter plus a two-stage delayed copy for core 1.
// Holding forces both the counter and the delay pipe to zero.
module round_counter
  import nonce_seq_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             i_hold,
  output logic [CNT_W-1:0] o_counter,
  output logic [CNT_W-1:0] o_counter_2d
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_d1;
  logic [CNT_W-1:0] r_d2;

  // Count while running; the pipe trails the counter by two cycles.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
    end else if (i_hold) begin
      r_cnt <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
    end else begin
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
      r_d1  <= r_cnt;
      r_d2  <= r_d1;
    end
  end

  assign o_counter    = r_cnt;
  assign o_counter_2d = r_d2;

endmodule

// File: rtl/nonce_sequencer.sv
// Nonce sequencer: walks a nonce range in ROUNDS-cycle blocks, tags the blocks
// launched to the two hash cores, and stops on the first hit or on exhaustion.
// Optional macro HASH_COUNT_EN adds the hashes_tested strobe counter.
module nonce_sequencer
  import nonce_seq_pkg::*;
#(
  parameter int unsigned ROUNDS    = 32,
  parameter int unsigned HASH_W    = 24,
  parameter int unsigned DRAIN_CYC = ROUNDS + 2
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_init,
  input  logic [NONCE_W-1:0] nonce_last,
  input  logic [HASH_W-1:0]  target,
  input  logic               hash_valid_0,
  input  logic [HASH_W-1:0]  hash_0,
  input  logic               hash_valid_1,
  input  logic [HASH_W-1:0]  hash_1,
  output logic [NONCE_W-1:0] nonce,
  output logic [CNT_W-1:0]   counter,
  output logic [CNT_W-1:0]   counter_2d,
  output logic               busy,
  output logic               found,
  output logic               done,
  output logic [NONCE_W-1:0] nonce_found
`ifdef HASH_COUNT_EN
  ,
  output logic [31:0]        hashes_tested
`endif
);

  localparam int unsigned      DRAIN_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(ROUNDS - 1);

  state_e             r_state;
  logic [NONCE_W-1:0] r_nonce;
  logic [NONCE_W-1:0] r_nonce_found;
  logic [NONCE_W-1:0] r_tag_0;
  logic [NONCE_W-1:0] r_tag_1;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_busy;
  logic               r_found;
  logic               r_done;

  logic w_active;
  logic w_start_ok;
  logic w_hit_0;
  logic w_hit_1;
  logic w_hit;
  logic w_last_round;
  logic w_drain_exp;
  logic w_hold;

  assign w_active     = (r_state == RUN) || (r_state == DRAIN);
  assign w_start_ok   = start && !w_active;
  assign w_hit_0      = w_active && hash_valid_0 && (hash_0 < target);
  assign w_hit_1      = w_active && hash_valid_1 && (hash_1 < target);
  assign w_hit        = w_hit_0 || w_hit_1;
  assign w_last_round = (counter == LAST_CNT);
  assign w_drain_exp  = (r_state == DRAIN) && (r_drain_cnt == '0);
  // Zero the counters on every edge that does not land in RUN/DRAIN, and on a
  // fresh start, so FOUND/DONE show a frozen counter immediately.
  assign w_hold       = abort || w_start_ok || !w_active || w_hit || w_drain_exp;

  round_counter #(
    .ROUNDS (ROUNDS)
  ) u_round_counter (
    .clk          (clk),
    .reset_L      (reset_L),
    .i_hold       (w_hold),
    .o_counter    (counter),
    .o_counter_2d (counter_2d)
  );

  // Tags mirror what the concatenator latches into each core's block.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_tag_0 <= '0;
      r_tag_1 <= '0;
    end else begin
      if (counter == '0)    r_tag_0 <= r_nonce;
      if (counter_2d == '0) r_tag_1 <= r_nonce;
    end
  end

  // Search FSM with registered status outputs; abort beats everything.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state       <= IDLE;
      r_nonce       <= '0;
      r_nonce_found <= '0;
      r_drain_cnt   <= '0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_done        <= 1'b0;
    end else if (abort) begin
      r_state       <= IDLE;
      r_nonce       <= nonce_init;
      r_nonce_found <= '0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_nonce <= nonce_init;
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (w_hit) begin
            // Core 0 wins a simultaneous hit.
            r_state       <= FOUND;
            r_nonce_found <= w_hit_0 ? r_tag_0 : r_tag_1;
            r_busy        <= 1'b0;
            r_found       <= 1'b1;
            r_done        <= 1'b1;
          end else if (r_state == RUN) begin
            if (w_last_round) begin
              if (r_nonce == nonce_last) begin
                r_state     <= DRAIN;
                r_drain_cnt <= DRAIN_LOAD;
              end else begin
                r_nonce <= r_nonce + 32'd1;
              end
            end
          end else if (w_drain_exp) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        FOUND, DONE: begin
          if (start) begin
            r_state       <= RUN;
            r_nonce       <= nonce_init;
            r_nonce_found <= '0;
            r_busy        <= 1'b1;
            r_found       <= 1'b0;
            r_done        <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef HASH_COUNT_EN
  logic [31:0] r_hashes;
  logic [32:0] w_hash_sum;

  assign w_hash_sum = {1'b0, r_hashes} + 33'(w_active && hash_valid_0)
                    + 33'(w_active && hash_valid_1);

  // Saturating count of strobes accepted while searching.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_hashes <= '0;
    end else if (w_start_ok && !abort) begin
      r_hashes <= '0;
    end else if (w_hash_sum[32]) begin
      r_hashes <= '1;
    end else begin
      r_hashes <= w_hash_sum[31:0];
    end
  end

  assign hashes_tested = r_hashes;
`endif

  assign nonce       = r_nonce;
  assign busy        = r_busy;
  assign found       = r_found;
  assign done        = r_done;
  assign nonce_found = r_nonce_found;

endmodule

// File: doc/nonce_sequencer.md
Name: nonce_sequencer

Overview:
- Control stage directly upstream of the block concatenator. It generates `nonce`, `counter` and `counter_2d`, which tell the concatenator when to latch each 128-bit block.
- It also tags each launched block with its nonce and checks the two hash cores' results against a difficulty target.
- It stops on the first hit, or on exhaustion of the nonce range, and reports the winning nonce.

Parameters:
- ROUNDS, 32: hash-core cycles per block; counter period. Legal range 4..64.
- HASH_W, 24: width of the hash prefix compared against target.
- DRAIN_CYC, ROUNDS+2: cycles spent collecting in-flight results after the last nonce.

Ports:
- clk  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a search from nonce_init. Honoured in IDLE, FOUND and DONE.
- abort  in  1  return to IDLE from any state.
- nonce_init  in  32  first nonce of the range.
- nonce_last  in  32  last nonce of the range, inclusive.
- target  in  HASH_W  a hit is hash < target, compared unsigned.
- hash_valid_0  in  1  core 0 result strobe.
- hash_0  in  HASH_W  core 0 hash prefix.
- hash_valid_1  in  1  core 1 result strobe.
- hash_1  in  HASH_W  core 1 hash prefix.
- nonce  out  32  current nonce, to the concatenator.
- counter  out  6  round counter, to the concatenator and core 0.
- counter_2d  out  6  counter delayed two cycles, to the concatenator and core 1.
- busy  out  1  high in RUN and DRAIN.
- found  out  1  high in FOUND.
- done  out  1  high in FOUND and DONE.
- nonce_found  out  32  winning nonce; valid while found=1.

Behaviour:
- Reset: all outputs and state are 0, state=IDLE. Reset is asynchronous, so it aborts a search mid-operation with no further result reporting.
- States: IDLE, RUN, DRAIN, FOUND, DONE. Every state except IDLE goes to IDLE on abort; abort has priority over start.
- Holding in IDLE, FOUND and DONE:
  - counter and counter_2d are held at 0.
  - nonce is held. In IDLE nonce equals nonce_init, so the downstream block keeps latching a harmless value.
- IDLE → RUN on start. Registered on that edge: nonce<=nonce_init, counter<=0, and the counter_2d pipe is cleared.
- RUN counting:
  - counter increments modulo ROUNDS every cycle.
  - When counter==ROUNDS-1, nonce<=nonce+1 (wraps modulo 2^32), so the new nonce is valid in the cycle counter returns to 0.
- counter_2d: a two-stage register pipe of counter. It is 0 at reset and after start.
- Nonce tags:
  - tag_0<=nonce on every cycle with counter==0.
  - tag_1<=nonce on every cycle with counter_2d==0.
  - These mirror exactly what the concatenator latches into its two blocks.
- Result checking: active in RUN and DRAIN only. Strobes in other states are ignored.
  - A hit on core 0 or core 1 → nonce_found<=the matching tag, then FOUND.
  - Both hit in the same cycle: core 0 wins.
- Exhaustion: in RUN, when counter==ROUNDS-1 and nonce==nonce_last → DRAIN. nonce is not incremented.
- DRAIN:
  - counter keeps running.
  - A down-counter is loaded with DRAIN_CYC-1.
  - A hit goes to FOUND; expiry without a hit goes to DONE with found=0.
  - If nonce_init==nonce_last, exactly one block is tested.
- FOUND and DONE: outputs are held until start (restart, nonce_found cleared) or abort.
- start in RUN or DRAIN is ignored.

Optional Feature:
- Macro: HASH_COUNT_EN.
- When defined:
  - Adds output hashes_tested[31:0], which increments once per accepted hash_valid_0 or hash_valid_1 strobe (by 2 if both fire).
  - The count saturates at 2^32-1 and is cleared on start and on reset.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package nonce_seq_pkg holds:
  - the state enum: IDLE=0, RUN=1, DRAIN=2, FOUND=3, DONE=4, 3-bit;
  - CNT_W=6;
  - NONCE_W=32.
- One sub-module, round_counter: modulo-ROUNDS counter plus the two-stage counter_2d pipe, with a hold input.
- Tagging, compare and FSM stay in the top.

Test Plan:
- Reset, then start with nonce_init=0x10, ROUNDS=32 → nonce=0x10 for 32 cycles; counter goes 0..31; nonce becomes 0x11 when counter wraps; counter_2d lags counter by exactly 2 cycles.
- Core 0 strobes hash_0=0x000010 with target=0x000100 in the cycle after tag_0=0x12 → found=1, done=1, nonce_found=0x12, counter frozen at 0.
- Both cores hit in the same cycle with tag_0=0x20 and tag_1=0x1F → nonce_found=0x20.
- nonce_init=0xFFFFFFFE, nonce_last=0x00000001, with no hits → nonce walks FFFFFFFE, FFFFFFFF, 0, 1; DRAIN lasts DRAIN_CYC cycles; DONE with found=0.
- abort asserted mid-RUN at the same edge as a core 1 hit → IDLE, found=0; a subsequent start restarts cleanly from nonce_init.
- reset_L asserted mid-DRAIN between clock edges → all outputs read 0 immediately, before the next clk edge; with HASH_COUNT_EN defined, hashes_tested is also 0.
